// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the IF/ID/EXE/WB core: forwarding selects, load-use stall, branch flush, halt, bitmap LDB/STB beats.
// Latency: forwarding and stall/flush controls are combinational from the current pipe contents; halted and beat index are registered.
// Backpressure: freezes PC/IFID (and IDEXE/EXE during bitmap moves) via hold outputs; never stalled itself.
module hazard_ctrl #(
    parameter int BMAP_BEATS = 96,   // 16-bit beats per 1536-bit bitmap transfer
    parameter int BEAT_W     = 7     // beat counter width, 2**BEAT_W must cover BMAP_BEATS
) (
    input  logic              clk,
    input  logic              rst_n,          // synchronous, active-high despite the name
    // ID stage (IFID register contents)
    input  logic              id_valid,
    input  logic [3:0]        id_rs1_addr,
    input  logic              id_rs1_used,
    input  logic [3:0]        id_rs2_addr,
    input  logic              id_rs2_used,
    input  logic [1:0]        id_bs_addr,
    input  logic              id_bs_used,
    // EXE stage (IDEXE register contents)
    input  logic              ex_valid,
    input  logic [3:0]        ex_rd_addr,
    input  logic              ex_wr_nreg,
    input  logic              ex_ld,
    input  logic [1:0]        ex_bd_addr,
    input  logic              ex_wr_breg,
    input  logic              ex_ldb,
    input  logic              ex_stb,
    input  logic              ex_halt,
    input  logic              ex_branch_taken,
    // WB stage
    input  logic [3:0]        wb_rd_addr,
    input  logic              wb_wr_nreg,
    input  logic [1:0]        wb_bd_addr,
    input  logic              wb_wr_breg,
    // Pipe register controls
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idexe_bubble,
    output logic              exe_hold,
    // EXE operand selects: 0 regfile, 1 EXE result, 2 WB result
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic [1:0]        fwd_bs,
    // Bitmap transfer / halt status
    output logic              bmap_busy,
    output logic [BEAT_W-1:0] bmap_beat,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BMAP   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_EX = 2'd1;
    localparam logic [1:0] SEL_WB = 2'd2;

    // Index of the final beat; the transfer ends on the cycle the counter shows it.
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BMAP_BEATS - 1);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;

    // ------------------------------------------------------------------
    // Producer/consumer matches. An LD in EXE has no result yet, so it
    // never forwards from EXE; bitmap loads have no such exclusion.
    // ------------------------------------------------------------------
    logic ex_nreg_src;
    logic ex_breg_src;
    logic rs1_ex_hit, rs1_wb_hit;
    logic rs2_ex_hit, rs2_wb_hit;
    logic bs_ex_hit,  bs_wb_hit;

    assign ex_nreg_src = ex_valid & ex_wr_nreg & ~ex_ld;
    assign ex_breg_src = ex_valid & ex_wr_breg;

    assign rs1_ex_hit  = id_rs1_used & ex_nreg_src & (ex_rd_addr == id_rs1_addr);
    assign rs1_wb_hit  = id_rs1_used & wb_wr_nreg  & (wb_rd_addr == id_rs1_addr);
    assign rs2_ex_hit  = id_rs2_used & ex_nreg_src & (ex_rd_addr == id_rs2_addr);
    assign rs2_wb_hit  = id_rs2_used & wb_wr_nreg  & (wb_rd_addr == id_rs2_addr);
    assign bs_ex_hit   = id_bs_used  & ex_breg_src & (ex_bd_addr == id_bs_addr);
    assign bs_wb_hit   = id_bs_used  & wb_wr_breg  & (wb_bd_addr == id_bs_addr);

    // The younger (EXE) producer always wins over WB.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_hit) begin
            sel = SEL_EX;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Operand selects are live in every state.
    always_comb begin
        fwd_rs1 = fwd_pick(rs1_ex_hit, rs1_wb_hit);
        fwd_rs2 = fwd_pick(rs2_ex_hit, rs2_wb_hit);
        fwd_bs  = fwd_pick(bs_ex_hit,  bs_wb_hit);
    end

    // ------------------------------------------------------------------
    // EXE-sourced events, all qualified by a real instruction in EXE.
    // ------------------------------------------------------------------
    logic halt_hit;
    logic bmap_hit;
    logic branch_hit;
    logic load_use_hit;

    assign halt_hit     = ex_valid & ex_halt;
    assign bmap_hit     = ex_valid & (ex_ldb | ex_stb);
    assign branch_hit   = ex_valid & ex_branch_taken;
    assign load_use_hit = id_valid & ex_valid & ex_ld & ex_wr_nreg &
                          ((id_rs1_used & (ex_rd_addr == id_rs1_addr)) |
                           (id_rs2_used & (ex_rd_addr == id_rs2_addr)));

    // State and beat counter register; reset wins even mid-transfer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_RUN;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and pipe controls; priority in RUN is halt > bitmap > branch > load-use.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        exe_hold     = 1'b0;
        bmap_busy    = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_RUN: begin
                beat_d = '0;
                if (halt_hit) begin
                    // Let the HALT retire; the freeze starts next cycle.
                    state_d = ST_HALTED;
                end else if (bmap_hit) begin
                    // Entry cycle is beat 0 of the transfer.
                    bmap_busy = 1'b1;
                    if (LAST_BEAT == '0) begin
                        // Single-beat transfer: entry is also the final beat.
                        idexe_bubble = 1'b1;
                    end else begin
                        exe_hold  = 1'b1;
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        beat_d    = BEAT_W'(1);
                        state_d   = ST_BMAP;
                    end
                end else if (branch_hit) begin
                    // Kill the wrong-path instructions in IF and ID.
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                end else if (load_use_hit) begin
                    // One bubble lets the LD reach WB, where it forwards.
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idexe_bubble = 1'b1;
                end
            end

            ST_BMAP: begin
                bmap_busy = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    // Release the pipe and retire the LDB/STB as a bubble.
                    idexe_bubble = 1'b1;
                    beat_d       = '0;
                    state_d      = ST_RUN;
                end else begin
                    exe_hold  = 1'b1;
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    beat_d    = beat_q + BEAT_W'(1);
                end
            end

            ST_HALTED: begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idexe_bubble = 1'b1;
                halted       = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
                beat_d  = '0;
            end
        endcase
    end

    assign bmap_beat = beat_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, bitmap sequencing, reset and halt.
// Latency: inputs change 1ns after the rising edge, outputs are compared 1ns later.
// Backpressure: none; the bench drives every input directly.
module tb_hazard_ctrl;

    localparam int BMAP_BEATS = 96;
    localparam int BEAT_W     = 7;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [3:0]        id_rs1_addr;
    logic              id_rs1_used;
    logic [3:0]        id_rs2_addr;
    logic              id_rs2_used;
    logic [1:0]        id_bs_addr;
    logic              id_bs_used;
    logic              ex_valid;
    logic [3:0]        ex_rd_addr;
    logic              ex_wr_nreg;
    logic              ex_ld;
    logic [1:0]        ex_bd_addr;
    logic              ex_wr_breg;
    logic              ex_ldb;
    logic              ex_stb;
    logic              ex_halt;
    logic              ex_branch_taken;
    logic [3:0]        wb_rd_addr;
    logic              wb_wr_nreg;
    logic [1:0]        wb_bd_addr;
    logic              wb_wr_breg;
    logic              pc_hold;
    logic              ifid_hold;
    logic              ifid_flush;
    logic              idexe_bubble;
    logic              exe_hold;
    logic [1:0]        fwd_rs1;
    logic [1:0]        fwd_rs2;
    logic [1:0]        fwd_bs;
    logic              bmap_busy;
    logic [BEAT_W-1:0] bmap_beat;
    logic              halted;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(
        .BMAP_BEATS (BMAP_BEATS),
        .BEAT_W     (BEAT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs2_used     (id_rs2_used),
        .id_bs_addr      (id_bs_addr),
        .id_bs_used      (id_bs_used),
        .ex_valid        (ex_valid),
        .ex_rd_addr      (ex_rd_addr),
        .ex_wr_nreg      (ex_wr_nreg),
        .ex_ld           (ex_ld),
        .ex_bd_addr      (ex_bd_addr),
        .ex_wr_breg      (ex_wr_breg),
        .ex_ldb          (ex_ldb),
        .ex_stb          (ex_stb),
        .ex_halt         (ex_halt),
        .ex_branch_taken (ex_branch_taken),
        .wb_rd_addr      (wb_rd_addr),
        .wb_wr_nreg      (wb_wr_nreg),
        .wb_bd_addr      (wb_bd_addr),
        .wb_wr_breg      (wb_wr_breg),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idexe_bubble    (idexe_bubble),
        .exe_hold        (exe_hold),
        .fwd_rs1         (fwd_rs1),
        .fwd_rs2         (fwd_rs2),
        .fwd_bs          (fwd_bs),
        .bmap_busy       (bmap_busy),
        .bmap_beat       (bmap_beat),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs may then be changed safely.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
        id_bs_addr = 0; id_bs_used = 0;
        ex_valid = 0; ex_rd_addr = 0; ex_wr_nreg = 0; ex_ld = 0; ex_bd_addr = 0; ex_wr_breg = 0;
        ex_ldb = 0; ex_stb = 0; ex_halt = 0; ex_branch_taken = 0;
        wb_rd_addr = 0; wb_wr_nreg = 0; wb_bd_addr = 0; wb_wr_breg = 0;
    endtask

    task automatic check_holds(input string tag, input logic pc, input logic ifid,
                               input logic flush, input logic bubble, input logic exeh);
        check({tag, ".pc_hold"},      32'(pc_hold),      32'(pc));
        check({tag, ".ifid_hold"},    32'(ifid_hold),    32'(ifid));
        check({tag, ".ifid_flush"},   32'(ifid_flush),   32'(flush));
        check({tag, ".idexe_bubble"}, 32'(idexe_bubble), 32'(bubble));
        check({tag, ".exe_hold"},     32'(exe_hold),     32'(exeh));
    endtask

    initial begin
        logic [31:0] r;

        // ---------------- reset ----------------
        rst_n = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check_holds("rst", 0, 0, 0, 0, 0);
        check("rst.bmap_busy", 32'(bmap_busy), 0);
        check("rst.bmap_beat", 32'(bmap_beat), 0);
        check("rst.halted",    32'(halted),    0);
        check("rst.fwd_rs1",   32'(fwd_rs1),   0);

        // ---------------- forwarding ----------------
        id_valid = 1; id_rs1_addr = 3; id_rs1_used = 1; id_rs2_addr = 3; id_rs2_used = 1;
        ex_valid = 1; ex_rd_addr = 3; ex_wr_nreg = 1;
        wb_rd_addr = 3; wb_wr_nreg = 1;
        #1;
        check("fwd.ex.rs1", 32'(fwd_rs1), 1);
        check("fwd.ex.rs2", 32'(fwd_rs2), 1);
        check("fwd.ex.pc_hold", 32'(pc_hold), 0);
        ex_wr_nreg = 0;
        #1;
        check("fwd.wb.rs1", 32'(fwd_rs1), 2);
        check("fwd.wb.rs2", 32'(fwd_rs2), 2);
        // EXE write present but EXE slot not valid: WB still supplies it
        ex_wr_nreg = 1; ex_valid = 0;
        #1;
        check("fwd.exinv.rs1", 32'(fwd_rs1), 2);
        // rs2 unused -> regfile even though everything matches
        ex_valid = 1; id_rs2_used = 0;
        #1;
        check("fwd.unused.rs2", 32'(fwd_rs2), 0);
        // LD in EXE never forwards; no ID instruction so no stall either
        id_valid = 0; ex_ld = 1;
        #1;
        check("fwd.ld.rs1",     32'(fwd_rs1), 2);
        check("fwd.ld.pc_hold", 32'(pc_hold), 0);
        // register 0 is an ordinary register; bitmap forwarding has no LD exclusion
        clear_inputs();
        id_rs1_addr = 0; id_rs1_used = 1; ex_valid = 1; ex_rd_addr = 0; ex_wr_nreg = 1;
        id_bs_addr = 2; id_bs_used = 1; ex_bd_addr = 2; ex_wr_breg = 1; ex_ld = 1;
        wb_bd_addr = 2; wb_wr_breg = 1;
        #1;
        check("fwd.r0.rs1", 32'(fwd_rs1), 2'd0);
        check("fwd.bs.ex",  32'(fwd_bs),  1);
        ex_bd_addr = 1;
        #1;
        check("fwd.bs.wb",  32'(fwd_bs),  2);
        wb_bd_addr = 3;
        #1;
        check("fwd.bs.rf",  32'(fwd_bs),  0);

        // ---------------- load-use ----------------
        clear_inputs();
        id_valid = 1; id_rs2_addr = 5; id_rs2_used = 1;
        ex_valid = 1; ex_ld = 1; ex_wr_nreg = 1; ex_rd_addr = 5;
        #1;
        check_holds("lu", 1, 1, 0, 1, 0);
        check("lu.fwd_rs2", 32'(fwd_rs2), 0);
        cyc();
        ex_valid = 0; ex_ld = 0; ex_wr_nreg = 0;
        wb_rd_addr = 5; wb_wr_nreg = 1;
        #1;
        check_holds("lu.next", 0, 0, 0, 0, 0);
        check("lu.next.fwd_rs2", 32'(fwd_rs2), 2);

        // ---------------- branch overrides load-use ----------------
        clear_inputs();
        id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1;
        ex_valid = 1; ex_ld = 1; ex_wr_nreg = 1; ex_rd_addr = 7; ex_branch_taken = 1;
        #1;
        check_holds("br", 0, 0, 1, 1, 0);
        ex_valid = 0;
        #1;
        check_holds("br.inv", 0, 0, 0, 0, 0);
        cyc();

        // ---------------- LDB: 96 beats, branch ignored at entry ----------------
        clear_inputs();
        ex_valid = 1; ex_ldb = 1; ex_wr_breg = 1; ex_branch_taken = 1;
        for (int k = 0; k < BMAP_BEATS; k++) begin
            #1;
            check("ldb.busy", 32'(bmap_busy), 1);
            check("ldb.beat", 32'(bmap_beat), 32'(k));
            check_holds("ldb", (k != BMAP_BEATS - 1), (k != BMAP_BEATS - 1), 0,
                        (k == BMAP_BEATS - 1), (k != BMAP_BEATS - 1));
            if (k == BMAP_BEATS - 1) clear_inputs();
            cyc();
        end
        #1;
        check("ldb.done.busy", 32'(bmap_busy), 0);
        check("ldb.done.beat", 32'(bmap_beat), 0);
        check_holds("ldb.done", 0, 0, 0, 0, 0);

        // ---------------- STB interrupted by reset at beat 40 ----------------
        ex_valid = 1; ex_stb = 1;
        for (int k = 0; k < 40; k++) cyc();
        check("stb.beat40", 32'(bmap_beat), 40);
        check("stb.busy40", 32'(bmap_busy), 1);
        rst_n = 1'b1;
        clear_inputs();
        cyc();
        rst_n = 1'b0;
        #1;
        check("stb.rst.busy", 32'(bmap_busy), 0);
        check("stb.rst.beat", 32'(bmap_beat), 0);
        check_holds("stb.rst", 0, 0, 0, 0, 0);

        // ---------------- HALT beats bitmap and branch ----------------
        ex_valid = 1; ex_halt = 1; ex_ldb = 1; ex_branch_taken = 1;
        #1;
        check("halt.now.halted", 32'(halted),     0);
        check("halt.now.busy",   32'(bmap_busy),  0);
        check("halt.now.flush",  32'(ifid_flush), 0);
        cyc();
        clear_inputs();
        #1;
        check("halt.halted", 32'(halted), 1);
        check_holds("halt", 1, 1, 0, 1, 0);
        for (int k = 0; k < 100; k++) begin
            r = $urandom;
            id_valid = r[0]; id_rs1_addr = r[4:1]; id_rs1_used = r[5]; id_rs2_addr = r[9:6];
            id_rs2_used = r[10]; id_bs_addr = r[12:11]; id_bs_used = r[13];
            ex_valid = r[14]; ex_rd_addr = r[18:15]; ex_wr_nreg = r[19]; ex_ld = r[20];
            ex_bd_addr = r[22:21]; ex_wr_breg = r[23]; ex_ldb = r[24]; ex_stb = r[25];
            ex_halt = r[26]; ex_branch_taken = r[27]; wb_rd_addr = r[31:28];
            r = $urandom;
            wb_wr_nreg = r[0]; wb_bd_addr = r[2:1]; wb_wr_breg = r[3];
            #1;
            check("halt.hold.halted", 32'(halted),    1);
            check("halt.hold.pc",     32'(pc_hold),   1);
            check("halt.hold.busy",   32'(bmap_busy), 0);
            check("halt.hold.flush",  32'(ifid_flush), 0);
            cyc();
        end
        rst_n = 1'b1;
        clear_inputs();
        cyc();
        rst_n = 1'b0;
        #1;
        check("halt.rst.halted", 32'(halted),  0);
        check("halt.rst.pc",     32'(pc_hold), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the four-stage CPU (IF, ID, EXE, WB).
- Detects data hazards between ID and EXE/WB and issues forwarding selects, load-use stalls, branch flushes and halt freeze.
- Sequences multi-beat bitmap LDB/STB transfers: EXE and upstream stages are frozen while a 1536-bit bitmap moves through 16-bit memory.
- Sits beside the IFID/IDEXE pipe registers and drives their hold/flush controls and the EXE operand muxes.

Parameters:
BMAP_BEATS, 96, number of 16-bit beats per bitmap transfer (1536/16)
BEAT_W, 7, width of beat counter; must satisfy 2^BEAT_W >= BMAP_BEATS

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-high (asserted = 1)
id_valid  in  1  IFID holds a real (non-flushed) instruction
id_rs1_addr  in  4  ID source register 1
id_rs1_used  in  1  ID reads rs1
id_rs2_addr  in  4  ID source register 2
id_rs2_used  in  1  ID reads rs2
id_bs_addr  in  2  ID bitmap source register
id_bs_used  in  1  ID reads bitmap source
ex_valid  in  1  IDEXE holds a real instruction
ex_rd_addr  in  4  EXE destination register
ex_wr_nreg  in  1  EXE writes normal register
ex_ld  in  1  EXE instruction is LD (data available only in WB)
ex_bd_addr  in  2  EXE bitmap destination
ex_wr_breg  in  1  EXE writes bitmap register
ex_ldb  in  1  EXE instruction is LDB
ex_stb  in  1  EXE instruction is STB
ex_halt  in  1  EXE instruction is HALT
ex_branch_taken  in  1  EXE resolved a taken branch/BRR/RET
wb_rd_addr  in  4  WB destination register
wb_wr_nreg  in  1  WB writes normal register
wb_bd_addr  in  2  WB bitmap destination
wb_wr_breg  in  1  WB writes bitmap register
pc_hold  out  1  freeze PC
ifid_hold  out  1  freeze IFID pipe
ifid_flush  out  1  mark IFID flushed next edge
idexe_bubble  out  1  load a NOP/flushed entry into IDEXE
exe_hold  out  1  freeze IDEXE and EXE outputs
fwd_rs1  out  2  rs1 select: 0 regfile, 1 EXE result, 2 WB result
fwd_rs2  out  2  rs2 select, same encoding
fwd_bs  out  2  bitmap source select, same encoding
bmap_busy  out  1  bitmap transfer in progress
bmap_beat  out  BEAT_W  current beat index (memory address offset)
halted  out  1  core halted

Behaviour:
- FSM states RUN, BMAP, HALTED. Reset -> RUN, beat counter 0, all outputs 0.
- Forwarding (combinational, all states): fwd_rsN = 1 if id_rsN_used & ex_valid & ex_wr_nreg & !ex_ld & ex_rd_addr==id_rsN_addr; else 2 if id_rsN_used & wb_wr_nreg & wb_rd_addr==id_rsN_addr; else 0. EXE match wins over WB. fwd_bs identical, using bitmap signals, no ld exclusion. Register 0 not special.
- Load-use (RUN only): id_valid & ex_valid & ex_ld & ex_wr_nreg & used-source match -> pc_hold=ifid_hold=idexe_bubble=1 for exactly one cycle; next cycle the LD is in WB and fwd selects 2.
- Branch (RUN): ex_valid & ex_branch_taken -> ifid_flush=1, idexe_bubble=1, same cycle. Overrides load-use stall: no hold.
- RUN->BMAP: ex_valid & (ex_ldb|ex_stb). That cycle and every BMAP cycle assert exe_hold, pc_hold, ifid_hold, bmap_busy. bmap_beat = 0 on entry cycle, increments each clk. On the cycle bmap_beat==BMAP_BEATS-1: exe_hold and holds drop, idexe_bubble=1, counter clears, ->RUN. Transfer occupies exactly BMAP_BEATS cycles.
- RUN->HALTED: ex_valid & ex_halt (highest priority). HALTED: pc_hold=ifid_hold=idexe_bubble=halted=1 until reset. halted rises the cycle after HALT is seen in EXE.
- Priority in RUN: halt > bitmap > branch > load-use.
- Reset asserted in any state (including mid-BMAP) -> RUN, counter 0, all outputs 0 on next edge.
- ex_valid=0 suppresses all EXE-sourced actions; id_valid=0 suppresses load-use stall.

Test Plan:
- Forward: EXE ADD writes r3, ID reads r3 as rs1 and rs2, WB also writes r3 -> fwd_rs1=fwd_rs2=1; remove EXE write -> both 2.
- Load-use: EXE LD r5, ID reads rs2=r5 -> one cycle pc_hold=ifid_hold=idexe_bubble=1, next cycle fwd_rs2=2, no hold.
- Branch + load-use same cycle: ex_branch_taken=1 with LD hazard -> ifid_flush=1, idexe_bubble=1, pc_hold=0.
- LDB with BMAP_BEATS=96: bmap_busy high 96 cycles, bmap_beat 0..95, exe_hold drops on beat 95 with idexe_bubble=1, back in RUN.
- Reset at beat 40 of STB -> next cycle bmap_busy=0, bmap_beat=0, all holds 0.
- HALT in EXE -> halted=1 next cycle and stays through 100 cycles of arbitrary inputs; rst_n=1 clears it.
